envelope_peak_detector: RTL and testbench

ENVELOPE_PEAK_DETECTOR -- requirements
Module: envelope_peak_detector

---
 rtl/hss_pkg.sv | 19 +
 rtl/moving_average.sv | 63 ++++++
 rtl/envelope_peak_detector.sv | 92 +++++++++
 tb/tb_envelope_peak_detector.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/hss_pkg.sv
// Shared definitions for the envelope/peak path: sample format and peak FSM encoding.
// Samples are signed Q2.29 in a 32-bit word.
package hss_pkg;

    localparam int DATA_W = 32;
    localparam int FRAC_W = 29;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_ABOVE      = 2'd1,
        ST_REFRACTORY = 2'd2
    } peak_state_t;

    // The upstream abs() wraps the most negative value; clamp it to full scale.
    function automatic logic signed [DATA_W-1:0] abs_guard(input logic signed [DATA_W-1:0] x);
        return x[DATA_W-1] ? {1'b0, {(DATA_W-1){1'b1}}} : x;
    endfunction

endpackage

// File: rtl/moving_average.sv
// Boxcar average over 2^WIN_LOG2 samples; result registered 1 cycle after the accepting in_valid.
// No backpressure: every in_valid is accepted, gaps freeze all state.
module moving_average
    import hss_pkg::*;
#(
    parameter int WIN_LOG2 = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic signed [DATA_W-1:0] sample,
    output logic signed [DATA_W-1:0] avg_data,
    output logic                     avg_valid
);

    localparam int DEPTH = 1 << WIN_LOG2;
    localparam int SUM_W = DATA_W + WIN_LOG2;

    logic signed [DATA_W-1:0] buf_mem [DEPTH];
    logic [WIN_LOG2-1:0]      wr_ptr;
    logic                     fill_done;
    logic signed [SUM_W-1:0]  sum;
    logic signed [SUM_W-1:0]  sum_next;
    logic signed [SUM_W-1:0]  new_ext;
    logic signed [SUM_W-1:0]  old_ext;
    logic signed [DATA_W-1:0] oldest;

    // Until the window has filled once, the slot being overwritten holds stale
    // data, so it is treated as zero instead of resetting the memory.
    always_comb begin
        oldest   = fill_done ? buf_mem[wr_ptr] : '0;
        new_ext  = {{WIN_LOG2{sample[DATA_W-1]}}, sample};
        old_ext  = {{WIN_LOG2{oldest[DATA_W-1]}}, oldest};
        sum_next = sum + new_ext - old_ext;
    end

    always_ff @(posedge clk) begin
        if (!rst && in_valid) begin
            buf_mem[wr_ptr] <= sample;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sum       <= '0;
            wr_ptr    <= '0;
            fill_done <= 1'b0;
            avg_data  <= '0;
            avg_valid <= 1'b0;
        end else begin
            avg_valid <= in_valid;
            if (in_valid) begin
                sum      <= sum_next;
                wr_ptr   <= wr_ptr + WIN_LOG2'(1);
                avg_data <= sum_next[WIN_LOG2 +: DATA_W];
                if (wr_ptr == '1) begin
                    fill_done <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/envelope_peak_detector.sv
// Smooths the envelogram and reports the maximum of each above-threshold excursion.
// env 1 cycle after in_valid, peak 1 cycle after the falling env sample; no backpressure.
module envelope_peak_detector
    import hss_pkg::*;
#(
    parameter int WIN_LOG2 = 4,
    parameter int REFRACT  = 64
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic signed [DATA_W-1:0] input_data,
    input  logic                     in_valid,
    input  logic signed [DATA_W-1:0] threshold,
    output logic signed [DATA_W-1:0] env_data,
    output logic                     env_valid,
    output logic                     peak_valid,
    output logic signed [DATA_W-1:0] peak_value,
    output logic [15:0]              peak_index
);

    localparam int CNT_W = (REFRACT > 1) ? $clog2(REFRACT) : 1;

    logic signed [DATA_W-1:0] sample_guarded;
    peak_state_t              state;
    logic [15:0]              sample_idx;
    logic [15:0]              max_idx;
    logic signed [DATA_W-1:0] max_val;
    logic [CNT_W-1:0]         refr_cnt;

    assign sample_guarded = abs_guard(input_data);

    moving_average #(
        .WIN_LOG2 (WIN_LOG2)
    ) u_mavg (
        .clk       (CLK),
        .rst       (RST),
        .in_valid  (in_valid),
        .sample    (sample_guarded),
        .avg_data  (env_data),
        .avg_valid (env_valid)
    );

    // sample_idx is the index of the env sample currently presented on env_data.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= ST_IDLE;
            sample_idx <= '0;
            max_idx    <= '0;
            max_val    <= '0;
            refr_cnt   <= '0;
            peak_valid <= 1'b0;
            peak_value <= '0;
            peak_index <= '0;
        end else begin
            peak_valid <= 1'b0;
            if (env_valid) begin
                sample_idx <= sample_idx + 16'd1;
                case (state)
                    ST_IDLE: begin
                        if (env_data > threshold) begin
                            state   <= ST_ABOVE;
                            max_val <= env_data;
                            max_idx <= sample_idx;
                        end
                    end
                    ST_ABOVE: begin
                        if (env_data <= threshold) begin
                            peak_valid <= 1'b1;
                            peak_value <= max_val;
                            peak_index <= max_idx;
                            refr_cnt   <= '0;
                            state      <= ST_REFRACTORY;
                        end else if (env_data > max_val) begin
                            max_val <= env_data;
                            max_idx <= sample_idx;
                        end
                    end
                    ST_REFRACTORY: begin
                        // The REFRACT-th sample is still ignored; IDLE sees the next one.
                        if (refr_cnt == CNT_W'(REFRACT - 1)) begin
                            state <= ST_IDLE;
                        end else begin
                            refr_cnt <= refr_cnt + CNT_W'(1);
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_envelope_peak_detector.sv
// Directed bench for envelope_peak_detector: vector table for reset/step, hand sequences for gaps, peaks, refractory, saturation.
module tb_envelope_peak_detector;

    logic               CLK = 1'b0;
    logic               RST;
    logic               in_valid;
    logic signed [31:0] input_data;
    logic signed [31:0] threshold;
    logic signed [31:0] env_data;
    logic               env_valid;
    logic               peak_valid;
    logic signed [31:0] peak_value;
    logic [15:0]        peak_index;

    always #5 CLK = ~CLK;

    envelope_peak_detector #(
        .WIN_LOG2 (4),
        .REFRACT  (64)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .input_data (input_data),
        .in_valid   (in_valid),
        .threshold  (threshold),
        .env_data   (env_data),
        .env_valid  (env_valid),
        .peak_valid (peak_valid),
        .peak_value (peak_value),
        .peak_index (peak_index)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int last_drv_cyc = 0;

    always @(posedge CLK) cyc <= cyc + 1;

    logic [31:0] pk_val_q [$];
    logic [15:0] pk_idx_q [$];
    int          pk_cyc_q [$];

    always @(negedge CLK) begin
        if (peak_valid === 1'b1) begin
            pk_val_q.push_back(peak_value);
            pk_idx_q.push_back(peak_index);
            pk_cyc_q.push_back(cyc);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Inputs change at a falling edge; outputs are read at the following falling edge.
    task automatic cycle(input logic r, input logic v, input logic [31:0] d);
        RST          = r;
        in_valid     = v;
        input_data   = d;
        last_drv_cyc = cyc;
        @(negedge CLK);
    endtask

    function automatic logic [31:0] pk_sample(input int n);
        if (n < 16)                return 32'h0;
        if (n < 48)                return 32'((n - 15) << 24);
        if (n < 79)                return 32'((79 - n) << 24);
        if (n >= 114 && n < 130)   return 32'h1000_0000;
        if (n >= 154 && n < 170)   return 32'h1000_0000;
        return 32'h0;
    endfunction

    typedef struct {
        logic        rst;
        logic        vld;
        logic [31:0] din;
        logic        exp_vld;
        logic [31:0] exp_env;
    } vec_t;

    vec_t vecs [23];
    int   drv [200];

    initial begin
        RST        = 1'b1;
        in_valid   = 1'b0;
        input_data = '0;
        threshold  = 32'h7FFF_FFFF;

        for (int i = 0; i < 3; i++)
            vecs[i] = '{1'b1, 1'b1, 32'h1000_0000, 1'b0, 32'h0};
        for (int i = 0; i < 20; i++)
            vecs[3 + i] = '{1'b0, 1'b1, 32'h1000_0000, 1'b1,
                            (i < 16) ? 32'((i + 1) << 24) : 32'h1000_0000};

        @(negedge CLK);

        // Reset with in_valid high, then a 20-sample step.
        for (int i = 0; i < 23; i++) begin
            cycle(vecs[i].rst, vecs[i].vld, vecs[i].din);
            check($sformatf("vec%0d env_valid", i), {31'b0, env_valid}, {31'b0, vecs[i].exp_vld});
            check($sformatf("vec%0d env_data", i), env_data, vecs[i].exp_env);
            if (vecs[i].rst) begin
                check($sformatf("vec%0d peak_valid", i), {31'b0, peak_valid}, 32'h0);
                check($sformatf("vec%0d peak_value", i), peak_value, 32'h0);
                check($sformatf("vec%0d peak_index", i), {16'b0, peak_index}, 32'h0);
            end
        end

        // Same step with two idle cycles between samples.
        cycle(1'b1, 1'b0, 32'h0);
        for (int i = 0; i < 20; i++) begin
            logic [31:0] exp_env;
            exp_env = (i < 16) ? 32'((i + 1) << 24) : 32'h1000_0000;
            cycle(1'b0, 1'b1, 32'h1000_0000);
            check($sformatf("gap%0d env_valid", i), {31'b0, env_valid}, 32'h1);
            check($sformatf("gap%0d env_data", i), env_data, exp_env);
            for (int g = 0; g < 2; g++) begin
                cycle(1'b0, 1'b0, 32'hDEAD_BEEF);
                check($sformatf("gap%0d idle%0d env_valid", i, g), {31'b0, env_valid}, 32'h0);
                check($sformatf("gap%0d idle%0d env_hold", i, g), env_data, exp_env);
            end
        end

        // Ramp peak, a bump inside the refractory window, and a bump after it.
        threshold = 32'h0400_0000;
        cycle(1'b1, 1'b0, 32'h0);
        pk_val_q.delete(); pk_idx_q.delete(); pk_cyc_q.delete();
        for (int n = 0; n < 200; n++) begin
            cycle(1'b0, 1'b1, pk_sample(n));
            drv[n] = last_drv_cyc;
            if (n == 54) check("ramp env at plateau", env_data, 32'h1C00_0000);
            if (n == 84) check("ramp env at fall", env_data, 32'h0370_0000);
        end
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 32'h0);
        check("ramp peak count", 32'(pk_val_q.size()), 32'd2);
        if (pk_val_q.size() >= 1) begin
            check("peak1 value", pk_val_q[0], 32'h1C00_0000);
            check("peak1 index", {16'b0, pk_idx_q[0]}, 32'd54);
            check("peak1 cycle", 32'(pk_cyc_q[0]), 32'(drv[84] + 2));
        end
        if (pk_val_q.size() >= 2) begin
            check("peak2 value", pk_val_q[1], 32'h1000_0000);
            check("peak2 index", {16'b0, pk_idx_q[1]}, 32'd169);
            check("peak2 cycle", 32'(pk_cyc_q[1]), 32'(drv[181] + 2));
        end

        // Saturation guard, then reset while a peak is pending.
        cycle(1'b1, 1'b0, 32'h0);
        pk_val_q.delete(); pk_idx_q.delete(); pk_cyc_q.delete();
        cycle(1'b0, 1'b1, 32'h8000_0000);
        check("sat env0", env_data, 32'h07FF_FFFF);
        cycle(1'b0, 1'b1, 32'h8000_0000);
        check("sat env1", env_data, 32'h0FFF_FFFF);
        cycle(1'b0, 1'b1, 32'h8000_0000);
        check("sat env2", env_data, 32'h17FF_FFFF);
        cycle(1'b1, 1'b1, 32'h1000_0000);
        check("mid-above rst env_valid", {31'b0, env_valid}, 32'h0);
        check("mid-above rst env_data", env_data, 32'h0);
        for (int n = 0; n < 36; n++) begin
            cycle(1'b0, 1'b1, (n < 16) ? 32'h1000_0000 : 32'h0);
            drv[n] = last_drv_cyc;
        end
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 32'h0);
        check("post-rst peak count", 32'(pk_val_q.size()), 32'd1);
        if (pk_val_q.size() >= 1) begin
            check("post-rst peak value", pk_val_q[0], 32'h1000_0000);
            check("post-rst peak index", {16'b0, pk_idx_q[0]}, 32'd15);
            check("post-rst peak cycle", 32'(pk_cyc_q[0]), 32'(drv[27] + 2));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
